// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage RISC-V core.
// Captures the decoded instruction word into the EX stage. Detects the
// single-cycle load-use hazard and turns an EX redirect into a flush bubble.
// Two saturating counters record hazard bubbles and flush bubbles.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    // Decoded instruction from ID
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm_val,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_rs1_read,
    input  logic             id_rs2_read,
    input  logic [3:0]       id_aluCont,
    input  logic             id_rdEn,
    input  logic             id_DMwriteEn,
    input  logic             id_DMread,
    input  logic             id_rdmuxSel,
    input  logic             id_alumux1sel,
    input  logic             id_alumux2sel,
    input  logic             id_pcloadEn,

    // Taken branch / jump resolved in EX
    input  logic             ex_redirect,

    // EX-stage register contents
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm_val,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_aluCont,
    output logic             ex_rdEn,
    output logic             ex_DMwriteEn,
    output logic             ex_DMread,
    output logic             ex_rdmuxSel,
    output logic             ex_alumux1sel,
    output logic             ex_alumux2sel,
    output logic             ex_pcloadEn,

    // Hazard stall towards IF and IF/ID
    output logic             stall,

    // Saturating bubble counters
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // One complete EX-stage word. An all-zero value is the canonical bubble.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm_val;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_cont;
        logic            rd_en;
        logic            dm_write_en;
        logic            dm_read;
        logic            rdmux_sel;
        logic            alumux1_sel;
        logic            alumux2_sel;
        logic            pcload_en;
    } ex_word_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ex_word_t         ex_q;
    ex_word_t         ex_d;
    ex_word_t         id_word;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    logic             rs1_used;
    logic             rs2_used;
    logic             rs1_match;
    logic             rs2_match;
    logic             hazard;

    // Assemble the incoming word; an invalid slot keeps its payload but can
    // never write the register file, memory or the PC.
    always_comb begin
        id_word             = '0;
        id_word.valid       = id_valid;
        id_word.pc          = id_pc;
        id_word.rs1_data    = id_rs1_data;
        id_word.rs2_data    = id_rs2_data;
        id_word.imm_val     = id_imm_val;
        id_word.rs1         = id_rs1;
        id_word.rs2         = id_rs2;
        id_word.rd          = id_rd;
        id_word.alu_cont    = id_aluCont;
        id_word.rd_en       = id_rdEn      & id_valid;
        id_word.dm_write_en = id_DMwriteEn & id_valid;
        id_word.dm_read     = id_DMread    & id_valid;
        id_word.rdmux_sel   = id_rdmuxSel;
        id_word.alumux1_sel = id_alumux1sel;
        id_word.alumux2_sel = id_alumux2sel;
        id_word.pcload_en   = id_pcloadEn  & id_valid;
    end

    // Load-use detection: a load in EX whose destination is read by ID.
    // Stores read rs2 as their data operand even if the decoder flag is low.
    always_comb begin
        rs1_used  = id_rs1_read;
        rs2_used  = id_rs2_read | id_DMwriteEn;
        rs1_match = rs1_used & (id_rs1 == ex_q.rd);
        rs2_match = rs2_used & (id_rs2 == ex_q.rd);
        hazard    = id_valid & ex_q.valid & ex_q.dm_read &
                    (ex_q.rd != 5'd0) & (rs1_match | rs2_match);
    end

    // A redirect squashes the held instruction, so it also cancels the stall.
    assign stall = hazard & ~ex_redirect;

    // Next EX word and counters: redirect beats hazard beats normal load.
    always_comb begin
        ex_d        = id_word;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ex_redirect) begin
            ex_d = '0;
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end else if (hazard) begin
            ex_d = '0;
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    // EX register and counters, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm_val    = ex_q.imm_val;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_aluCont    = ex_q.alu_cont;
    assign ex_rdEn       = ex_q.rd_en;
    assign ex_DMwriteEn  = ex_q.dm_write_en;
    assign ex_DMread     = ex_q.dm_read;
    assign ex_rdmuxSel   = ex_q.rdmux_sel;
    assign ex_alumux1sel = ex_q.alumux1_sel;
    assign ex_alumux2sel = ex_q.alumux2_sel;
    assign ex_pcloadEn   = ex_q.pcload_en;

    assign stall_count   = stall_cnt_q;
    assign flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm_val;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_rs1_read, id_rs2_read;
    logic [3:0]       id_aluCont;
    logic             id_rdEn, id_DMwriteEn, id_DMread, id_rdmuxSel;
    logic             id_alumux1sel, id_alumux2sel, id_pcloadEn;
    logic             ex_redirect;

    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm_val;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [3:0]       ex_aluCont;
    logic             ex_rdEn, ex_DMwriteEn, ex_DMread, ex_rdmuxSel;
    logic             ex_alumux1sel, ex_alumux2sel, ex_pcloadEn;
    logic             stall;
    logic [CNT_W-1:0] stall_count, flush_count;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm_val(id_imm_val),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
        .id_aluCont(id_aluCont), .id_rdEn(id_rdEn), .id_DMwriteEn(id_DMwriteEn),
        .id_DMread(id_DMread), .id_rdmuxSel(id_rdmuxSel),
        .id_alumux1sel(id_alumux1sel), .id_alumux2sel(id_alumux2sel),
        .id_pcloadEn(id_pcloadEn), .ex_redirect(ex_redirect),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm_val(ex_imm_val),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_aluCont(ex_aluCont),
        .ex_rdEn(ex_rdEn), .ex_DMwriteEn(ex_DMwriteEn), .ex_DMread(ex_DMread),
        .ex_rdmuxSel(ex_rdmuxSel), .ex_alumux1sel(ex_alumux1sel),
        .ex_alumux2sel(ex_alumux2sel), .ex_pcloadEn(ex_pcloadEn),
        .stall(stall), .stall_count(stall_count), .flush_count(flush_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        bit            valid;
        bit [XLEN-1:0] pc, rs1d, rs2d, imm;
        bit [4:0]      rs1, rs2, rd;
        bit [3:0]      alu;
        bit            rd_en, wr_en, rd_mem, rdmux, amux1, amux2, pcl;
    } mword_t;

    mword_t m;
    int     m_sc = 0;
    int     m_fc = 0;
    bit     model_live = 1'b0;

    // Load in EX whose nonzero rd is a source of the valid ID instruction.
    function automatic bit m_hazard();
        bit uses1, uses2;
        uses1 = id_rs1_read;
        uses2 = id_rs2_read || id_DMwriteEn;
        return id_valid && m.valid && m.rd_mem && (m.rd != 0) &&
               ((uses1 && id_rs1 == m.rd) || (uses2 && id_rs2 == m.rd));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m = '0; m_sc = 0; m_fc = 0; model_live = 1'b1;
        end else if (ex_redirect) begin
            m = '0;
            if (m_fc < SAT) m_fc = m_fc + 1;
        end else if (m_hazard()) begin
            m = '0;
            if (m_sc < SAT) m_sc = m_sc + 1;
        end else begin
            m.valid = id_valid;
            m.pc = id_pc; m.rs1d = id_rs1_data; m.rs2d = id_rs2_data; m.imm = id_imm_val;
            m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd; m.alu = id_aluCont;
            m.rd_en  = id_rdEn      && id_valid;
            m.wr_en  = id_DMwriteEn && id_valid;
            m.rd_mem = id_DMread    && id_valid;
            m.pcl    = id_pcloadEn  && id_valid;
            m.rdmux = id_rdmuxSel; m.amux1 = id_alumux1sel; m.amux2 = id_alumux2sel;
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            chk("stall",       64'(stall),         64'(m_hazard() && !ex_redirect));
            chk("ex_valid",    64'(ex_valid),      64'(m.valid));
            chk("ex_pc",       64'(ex_pc),         64'(m.pc));
            chk("ex_rs1_data", 64'(ex_rs1_data),   64'(m.rs1d));
            chk("ex_rs2_data", 64'(ex_rs2_data),   64'(m.rs2d));
            chk("ex_imm_val",  64'(ex_imm_val),    64'(m.imm));
            chk("ex_rs1",      64'(ex_rs1),        64'(m.rs1));
            chk("ex_rs2",      64'(ex_rs2),        64'(m.rs2));
            chk("ex_rd",       64'(ex_rd),         64'(m.rd));
            chk("ex_aluCont",  64'(ex_aluCont),    64'(m.alu));
            chk("ex_rdEn",     64'(ex_rdEn),       64'(m.rd_en));
            chk("ex_DMwriteEn",64'(ex_DMwriteEn),  64'(m.wr_en));
            chk("ex_DMread",   64'(ex_DMread),     64'(m.rd_mem));
            chk("ex_rdmuxSel", 64'(ex_rdmuxSel),   64'(m.rdmux));
            chk("ex_alumux1",  64'(ex_alumux1sel), 64'(m.amux1));
            chk("ex_alumux2",  64'(ex_alumux2sel), 64'(m.amux2));
            chk("ex_pcloadEn", 64'(ex_pcloadEn),   64'(m.pcl));
            chk("stall_count", 64'(stall_count),   64'(m_sc));
            chk("flush_count", 64'(flush_count),   64'(m_fc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; ex_redirect = 1'b0;
        id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm_val = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rs1_read = 1'b0; id_rs2_read = 1'b0;
        id_aluCont = '0; id_rdEn = 1'b0; id_DMwriteEn = 1'b0; id_DMread = 1'b0;
        id_rdmuxSel = 1'b0; id_alumux1sel = 1'b0; id_alumux2sel = 1'b0; id_pcloadEn = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ID holds a load writing register rd
    task automatic put_load(input logic [4:0] rd);
        idle();
        id_valid = 1'b1; id_DMread = 1'b1; id_rdEn = 1'b1; id_rdmuxSel = 1'b1;
        id_rd = rd; id_pc = 32'h200; id_imm_val = 32'h4;
    endtask

    task automatic randomize_inputs();
        rst           = ($urandom_range(0, 99) < 2);
        ex_redirect   = ($urandom_range(0, 99) < 10);
        id_valid      = ($urandom_range(0, 99) < 85);
        id_pc         = $urandom;
        id_rs1_data   = $urandom;
        id_rs2_data   = $urandom;
        id_imm_val    = $urandom;
        id_rs1        = 5'($urandom_range(0, 3));
        id_rs2        = 5'($urandom_range(0, 3));
        id_rd         = 5'($urandom_range(0, 3));
        id_rs1_read   = 1'($urandom);
        id_rs2_read   = 1'($urandom);
        id_aluCont    = 4'($urandom);
        id_rdEn       = 1'($urandom);
        id_DMwriteEn  = ($urandom_range(0, 99) < 25);
        id_DMread     = ($urandom_range(0, 99) < 40);
        id_rdmuxSel   = 1'($urandom);
        id_alumux1sel = 1'($urandom);
        id_alumux2sel = 1'($urandom);
        id_pcloadEn   = 1'($urandom);
    endtask

    initial begin
        idle();
        rst = 1'b1;

        // Reset held two cycles with a valid instruction present
        randomize_inputs();
        rst = 1'b1; id_valid = 1'b1; ex_redirect = 1'b0;
        step();
        step();
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_ex_pc", 64'(ex_pc), 64'd0);
        chk("rst_stall_count", 64'(stall_count), 64'd0);
        chk("rst_flush_count", 64'(flush_count), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);

        // Pass-through
        idle();
        id_valid = 1'b1; id_pc = 32'h100; id_aluCont = 4'b0000; id_rdEn = 1'b1; id_rd = 5'd5;
        #1 chk("pt_stall_before", 64'(stall), 64'd0);
        step();
        chk("pt_ex_valid", 64'(ex_valid), 64'd1);
        chk("pt_ex_pc", 64'(ex_pc), 64'h100);
        chk("pt_ex_rd", 64'(ex_rd), 64'd5);
        chk("pt_stall_after", 64'(stall), 64'd0);

        // Load-use: load rd=7 then add reading rs2=7
        put_load(5'd7);
        step();
        idle();
        id_valid = 1'b1; id_rs2 = 5'd7; id_rs2_read = 1'b1; id_rs1 = 5'd1; id_rs1_read = 1'b1;
        id_rd = 5'd8; id_rdEn = 1'b1; id_pc = 32'h204;
        #1 chk("lu_stall", 64'(stall), 64'd1);
        step();
        chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
        chk("lu_stall_count", 64'(stall_count), 64'd1);
        chk("lu_stall_dropped", 64'(stall), 64'd0);
        step();
        chk("lu_add_valid", 64'(ex_valid), 64'd1);
        chk("lu_add_rd", 64'(ex_rd), 64'd8);
        chk("lu_add_pc", 64'(ex_pc), 64'h204);

        // Load with rd=0 never stalls
        put_load(5'd0);
        step();
        idle();
        id_valid = 1'b1; id_rs2 = 5'd0; id_rs2_read = 1'b1; id_rdEn = 1'b1; id_rd = 5'd9;
        #1 chk("lu_rd0_stall", 64'(stall), 64'd0);
        step();

        // Store data hazard: rs2 consumed by store although rs2_read = 0
        put_load(5'd3);
        step();
        idle();
        id_valid = 1'b1; id_rs2 = 5'd3; id_rs2_read = 1'b0; id_DMwriteEn = 1'b1;
        #1 chk("st_stall", 64'(stall), 64'd1);
        step();
        chk("st_stall_count", 64'(stall_count), 64'd2);
        chk("st_stall_release", 64'(stall), 64'd0);
        step();
        chk("st_store_in_ex", 64'(ex_DMwriteEn), 64'd1);

        // Flush coincides with hazard: counts only as a flush
        do_reset();
        put_load(5'd7);
        step();
        idle();
        id_valid = 1'b1; id_rs1 = 5'd7; id_rs1_read = 1'b1; ex_redirect = 1'b1;
        #1 chk("fh_stall", 64'(stall), 64'd0);
        step();
        chk("fh_bubble_valid", 64'(ex_valid), 64'd0);
        chk("fh_flush_count", 64'(flush_count), 64'd1);
        chk("fh_stall_count", 64'(stall_count), 64'd0);

        // Saturation: 20 consecutive redirects on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            idle();
            id_valid = 1'b1; id_pc = 32'(i); ex_redirect = 1'b1;
            step();
        end
        chk("sat_flush_count", 64'(flush_count), 64'd15);
        chk("sat_stall_count", 64'(stall_count), 64'd0);

        // Randomized traffic, checked every cycle by the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
        end

        idle();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
